// File: rtl/pwm_config_sequencer_if.sv
// pwm_config_sequencer_if: host write port (valid/ready, address, data) for the PWM config sequencer
// Ports:
//  CfgValid  host -> block  write request
//  CfgReady  block -> host  write accepted this cycle when high with CfgValid
//  CfgAddr   host -> block  0=Compare 1=PWMMaxCount 2=TriangleStepSize 3=DeadTimeCount 4=commit
//  CfgData   host -> block  write data, unused for commit
interface pwm_config_sequencer_if #(parameter int BIT_WIDTH = 16) ();
  logic CfgValid;
  logic CfgReady;
  logic [2:0] CfgAddr;
  logic [BIT_WIDTH-1:0] CfgData;
  modport master (output CfgValid, CfgAddr, CfgData, input CfgReady);
  modport slave (input CfgValid, CfgAddr, CfgData, output CfgReady);
endinterface

// File: rtl/pwm_config_sequencer.sv
// pwm_config_sequencer: stages PhaseX PWM settings and applies them atomically at a carrier period boundary
// Ports:
//  MClk, RstN        clock and synchronous active-low reset
//  cfg               host write port (slave side)
//  PeriodSync        one-cycle pulse at the carrier period boundary
//  Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount   active configuration
//  Busy              commit in flight (waiting for sync or applying)
//  CommitDone        one-cycle pulse when a commit completes
//  CfgError          one-cycle pulse when a request is rejected or aborted
//  CfgErrCode        last error cause: 0 bad address, 1 validation, 2 sync timeout
module pwm_config_sequencer #(
  parameter int BIT_WIDTH = 16,
  parameter int DEF_MAXCOUNT = 1000,
  parameter int DEF_COMPARE = 500,
  parameter int DEF_STEP = 1,
  parameter int DEF_DEADTIME = 10,
  parameter int SYNC_TIMEOUT = 65535
) (
  input  logic MClk,
  input  logic RstN,
  pwm_config_sequencer_if.slave cfg,
  input  logic PeriodSync,
  output logic [BIT_WIDTH-1:0] Compare,
  output logic [BIT_WIDTH-1:0] PWMMaxCount,
  output logic [BIT_WIDTH-1:0] TriangleStepSize,
  output logic [BIT_WIDTH-1:0] DeadTimeCount,
  output logic Busy,
  output logic CommitDone,
  output logic CfgError,
  output logic [1:0] CfgErrCode
);
  localparam int TO_W = SYNC_TIMEOUT > 1 ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] LAST_CNT = TO_W'(SYNC_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, STAGED, WAIT_SYNC, APPLY} stateE;
  stateE state, stateNext;
  logic [TO_W-1:0] cnt, cntNext;
  logic [BIT_WIDTH-1:0] stCmp, stMax, stStep, stDead;
  logic xfer, stagedOk, doneNext, errNext;
  logic [1:0] codeNext;
  assign cfg.CfgReady = (state == IDLE) || (state == STAGED);
  assign Busy = (state == WAIT_SYNC) || (state == APPLY);
  assign xfer = cfg.CfgValid && cfg.CfgReady;
  // Doubling dead time in one extra bit so large values cannot wrap past the check.
  assign stagedOk = (stMax != '0) && (stCmp <= stMax) && (stStep != '0) && (stStep <= stMax)
                    && ({stDead, 1'b0} < {1'b0, stMax});
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    doneNext = 1'b0;
    errNext = 1'b0;
    codeNext = CfgErrCode;
    unique case (state)
      IDLE, STAGED: if (xfer) begin
        if (cfg.CfgAddr < 3'd4) stateNext = STAGED;
        else if (cfg.CfgAddr == 3'd4) begin
          if (state == IDLE) doneNext = 1'b1;
          else if (stagedOk) begin
            stateNext = WAIT_SYNC;
            cntNext = '0;
          end else begin
            errNext = 1'b1;
            codeNext = 2'd1;
          end
        end else begin
          errNext = 1'b1;
          codeNext = 2'd0;
        end
      end
      WAIT_SYNC: begin
        cntNext = cnt + 1'b1;
        // A sync pulse on the final allowed cycle still wins over the timeout.
        if (PeriodSync) stateNext = APPLY;
        else if (cnt == LAST_CNT) begin
          stateNext = STAGED;
          errNext = 1'b1;
          codeNext = 2'd2;
        end
      end
      default: begin
        stateNext = IDLE;
        doneNext = 1'b1;
      end
    endcase
  end
  always_ff @(posedge MClk) begin
    if (!RstN) begin
      state <= IDLE;
      cnt <= '0;
      CommitDone <= 1'b0;
      CfgError <= 1'b0;
      CfgErrCode <= 2'd0;
      stCmp <= BIT_WIDTH'(DEF_COMPARE);
      stMax <= BIT_WIDTH'(DEF_MAXCOUNT);
      stStep <= BIT_WIDTH'(DEF_STEP);
      stDead <= BIT_WIDTH'(DEF_DEADTIME);
      Compare <= BIT_WIDTH'(DEF_COMPARE);
      PWMMaxCount <= BIT_WIDTH'(DEF_MAXCOUNT);
      TriangleStepSize <= BIT_WIDTH'(DEF_STEP);
      DeadTimeCount <= BIT_WIDTH'(DEF_DEADTIME);
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      CommitDone <= doneNext;
      CfgError <= errNext;
      CfgErrCode <= codeNext;
      if (xfer && cfg.CfgAddr == 3'd0) stCmp <= cfg.CfgData;
      if (xfer && cfg.CfgAddr == 3'd1) stMax <= cfg.CfgData;
      if (xfer && cfg.CfgAddr == 3'd2) stStep <= cfg.CfgData;
      if (xfer && cfg.CfgAddr == 3'd3) stDead <= cfg.CfgData;
      if (state == APPLY) begin
        Compare <= stCmp;
        PWMMaxCount <= stMax;
        TriangleStepSize <= stStep;
        DeadTimeCount <= stDead;
      end
    end
  end
endmodule

// File: tb/tb_pwm_config_sequencer.sv
// tb_pwm_config_sequencer: directed scenarios for pwm_config_sequencer with hand-computed expectations
module tb_pwm_config_sequencer;
  logic MClk = 1'b0;
  logic RstN = 1'b0;
  logic PeriodSync = 1'b0;
  logic [15:0] Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount;
  logic Busy, CommitDone, CfgError;
  logic [1:0] CfgErrCode;
  int passCnt = 0;
  int totalCnt = 0;
  pwm_config_sequencer_if #(.BIT_WIDTH(16)) cfgIf ();
  pwm_config_sequencer #(.SYNC_TIMEOUT(8)) dut (
    .MClk(MClk), .RstN(RstN), .cfg(cfgIf), .PeriodSync(PeriodSync),
    .Compare(Compare), .PWMMaxCount(PWMMaxCount), .TriangleStepSize(TriangleStepSize),
    .DeadTimeCount(DeadTimeCount), .Busy(Busy), .CommitDone(CommitDone),
    .CfgError(CfgError), .CfgErrCode(CfgErrCode)
  );
  always #5 MClk = ~MClk;
  task automatic cyc();
    @(posedge MClk);
    #1;
  endtask
  task automatic write(input logic [2:0] addr, input logic [15:0] data);
    cfgIf.CfgValid = 1'b1;
    cfgIf.CfgAddr = addr;
    cfgIf.CfgData = data;
    cyc();
    cfgIf.CfgValid = 1'b0;
  endtask
  task automatic test_reset();
    RstN = 1'b0;
    cyc();
    cyc();
    RstN = 1'b1;
    totalCnt++; if (Compare !== 16'd500) $display("FAIL rst_compare got %0d want 500", Compare); else passCnt++;
    totalCnt++; if (PWMMaxCount !== 16'd1000) $display("FAIL rst_max got %0d want 1000", PWMMaxCount); else passCnt++;
    totalCnt++; if (TriangleStepSize !== 16'd1) $display("FAIL rst_step got %0d want 1", TriangleStepSize); else passCnt++;
    totalCnt++; if (DeadTimeCount !== 16'd10) $display("FAIL rst_dead got %0d want 10", DeadTimeCount); else passCnt++;
    totalCnt++; if (cfgIf.CfgReady !== 1'b1) $display("FAIL rst_ready got %b want 1", cfgIf.CfgReady); else passCnt++;
    totalCnt++; if (Busy !== 1'b0) $display("FAIL rst_busy got %b want 0", Busy); else passCnt++;
    totalCnt++; if ({CommitDone, CfgError, CfgErrCode} !== 4'b0) $display("FAIL rst_flags got %b want 0000", {CommitDone, CfgError, CfgErrCode}); else passCnt++;
  endtask
  task automatic test_commit();
    write(3'd0, 16'd300);
    totalCnt++; if (Compare !== 16'd500) $display("FAIL stage_no_effect got %0d want 500", Compare); else passCnt++;
    write(3'd4, 16'd0);
    totalCnt++; if (Busy !== 1'b1) $display("FAIL commit_busy got %b want 1", Busy); else passCnt++;
    for (int i = 0; i < 4; i++) begin
      totalCnt++; if (cfgIf.CfgReady !== 1'b0) $display("FAIL wait_ready[%0d] got %b want 0", i, cfgIf.CfgReady); else passCnt++;
      cyc();
    end
    PeriodSync = 1'b1;
    cyc();
    PeriodSync = 1'b0;
    totalCnt++; if (Compare !== 16'd500 || CommitDone !== 1'b0) $display("FAIL apply_cycle got cmp=%0d done=%b want 500/0", Compare, CommitDone); else passCnt++;
    totalCnt++; if (cfgIf.CfgReady !== 1'b0) $display("FAIL apply_ready got %b want 0", cfgIf.CfgReady); else passCnt++;
    cyc();
    totalCnt++; if (Compare !== 16'd300 || CommitDone !== 1'b1) $display("FAIL commit_out got cmp=%0d done=%b want 300/1", Compare, CommitDone); else passCnt++;
    totalCnt++; if (cfgIf.CfgReady !== 1'b1 || Busy !== 1'b0) $display("FAIL commit_idle got rdy=%b busy=%b want 1/0", cfgIf.CfgReady, Busy); else passCnt++;
    cyc();
    totalCnt++; if (CommitDone !== 1'b0) $display("FAIL done_width got %b want 0", CommitDone); else passCnt++;
  endtask
  task automatic test_validation();
    write(3'd1, 16'd100);
    write(3'd3, 16'd50);
    write(3'd4, 16'd0);
    totalCnt++; if (CfgError !== 1'b1 || CfgErrCode !== 2'd1) $display("FAIL val_err got err=%b code=%0d want 1/1", CfgError, CfgErrCode); else passCnt++;
    totalCnt++; if (CommitDone !== 1'b0) $display("FAIL val_done got %b want 0", CommitDone); else passCnt++;
    totalCnt++; if ({Compare, PWMMaxCount, DeadTimeCount} !== {16'd300, 16'd1000, 16'd10}) $display("FAIL val_outputs got %0d/%0d/%0d want 300/1000/10", Compare, PWMMaxCount, DeadTimeCount); else passCnt++;
    totalCnt++; if (cfgIf.CfgReady !== 1'b1 || Busy !== 1'b0) $display("FAIL val_staged got rdy=%b busy=%b want 1/0", cfgIf.CfgReady, Busy); else passCnt++;
    cyc();
    totalCnt++; if (CfgError !== 1'b0 || CfgErrCode !== 2'd1) $display("FAIL val_hold got err=%b code=%0d want 0/1", CfgError, CfgErrCode); else passCnt++;
    write(3'd0, 16'd40);
    write(3'd3, 16'd5);
  endtask
  task automatic test_timeout();
    write(3'd4, 16'd0);
    for (int i = 0; i < 8; i++) begin
      totalCnt++; if (Busy !== 1'b1 || CfgError !== 1'b0) $display("FAIL to_wait[%0d] got busy=%b err=%b want 1/0", i, Busy, CfgError); else passCnt++;
      cyc();
    end
    totalCnt++; if (CfgError !== 1'b1 || CfgErrCode !== 2'd2) $display("FAIL to_err got err=%b code=%0d want 1/2", CfgError, CfgErrCode); else passCnt++;
    totalCnt++; if (Busy !== 1'b0 || cfgIf.CfgReady !== 1'b1 || Compare !== 16'd300) $display("FAIL to_state got busy=%b rdy=%b cmp=%0d want 0/1/300", Busy, cfgIf.CfgReady, Compare); else passCnt++;
    cyc();
    write(3'd4, 16'd0);
    PeriodSync = 1'b1;
    cyc();
    PeriodSync = 1'b0;
    cyc();
    totalCnt++; if ({Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount} !== {16'd40, 16'd100, 16'd1, 16'd5}) $display("FAIL to_recommit got %0d/%0d/%0d/%0d want 40/100/1/5", Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount); else passCnt++;
    totalCnt++; if (CommitDone !== 1'b1 || CfgError !== 1'b0) $display("FAIL to_done got done=%b err=%b want 1/0", CommitDone, CfgError); else passCnt++;
    cyc();
  endtask
  task automatic test_bad_addr_sync_ignore();
    write(3'd6, 16'd77);
    totalCnt++; if (CfgError !== 1'b1 || CfgErrCode !== 2'd0) $display("FAIL badaddr got err=%b code=%0d want 1/0", CfgError, CfgErrCode); else passCnt++;
    totalCnt++; if (Busy !== 1'b0 || Compare !== 16'd40) $display("FAIL badaddr_state got busy=%b cmp=%0d want 0/40", Busy, Compare); else passCnt++;
    write(3'd4, 16'd0);
    totalCnt++; if (CommitDone !== 1'b1 || CfgError !== 1'b0 || Busy !== 1'b0) $display("FAIL idle_commit got done=%b err=%b busy=%b want 1/0/0", CommitDone, CfgError, Busy); else passCnt++;
    write(3'd0, 16'd60);
    PeriodSync = 1'b1;
    write(3'd4, 16'd0);
    PeriodSync = 1'b0;
    totalCnt++; if (Busy !== 1'b1) $display("FAIL sync_ign1 got busy=%b want 1", Busy); else passCnt++;
    cyc();
    totalCnt++; if (Busy !== 1'b1 || Compare !== 16'd40) $display("FAIL sync_ign2 got busy=%b cmp=%0d want 1/40", Busy, Compare); else passCnt++;
    PeriodSync = 1'b1;
    cyc();
    PeriodSync = 1'b0;
    totalCnt++; if (Compare !== 16'd40 || Busy !== 1'b1) $display("FAIL sync_apply got cmp=%0d busy=%b want 40/1", Compare, Busy); else passCnt++;
    cyc();
    totalCnt++; if (Compare !== 16'd60 || CommitDone !== 1'b1) $display("FAIL sync_done got cmp=%0d done=%b want 60/1", Compare, CommitDone); else passCnt++;
    cyc();
  endtask
  task automatic test_reset_mid_commit();
    write(3'd0, 16'd42);
    write(3'd4, 16'd0);
    cyc();
    RstN = 1'b0;
    cyc();
    RstN = 1'b1;
    totalCnt++; if ({Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount} !== {16'd500, 16'd1000, 16'd1, 16'd10}) $display("FAIL midrst_out got %0d/%0d/%0d/%0d want 500/1000/1/10", Compare, PWMMaxCount, TriangleStepSize, DeadTimeCount); else passCnt++;
    totalCnt++; if (Busy !== 1'b0 || cfgIf.CfgReady !== 1'b1 || CommitDone !== 1'b0) $display("FAIL midrst_state got busy=%b rdy=%b done=%b want 0/1/0", Busy, cfgIf.CfgReady, CommitDone); else passCnt++;
    PeriodSync = 1'b1;
    cyc();
    PeriodSync = 1'b0;
    cyc();
    totalCnt++; if (CommitDone !== 1'b0 || Compare !== 16'd500) $display("FAIL midrst_nodone got done=%b cmp=%0d want 0/500", CommitDone, Compare); else passCnt++;
    write(3'd4, 16'd0);
    totalCnt++; if (CommitDone !== 1'b1 || Compare !== 16'd500) $display("FAIL midrst_discard got done=%b cmp=%0d want 1/500", CommitDone, Compare); else passCnt++;
  endtask
  initial begin
    cfgIf.CfgValid = 1'b0;
    cfgIf.CfgAddr = 3'd0;
    cfgIf.CfgData = 16'd0;
    test_reset();
    test_commit();
    test_validation();
    test_timeout();
    test_bad_addr_sync_ignore();
    test_reset_mid_commit();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
